// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared constants, FSM state encodings and parity helper for data_mem_ctrl
package data_mem_pkg;

  localparam int DEF_DW    = 8;
  localparam int DEF_AW    = 8;
  localparam int DEF_DEPTH = 256;

  // Two-state controller: serving requests, or zeroing the array one word per cycle
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  // Even parity: the returned bit makes the total count of ones (data + parity) even.
  // Callers zero-extend their data to 64 bits, so DW must not exceed 64.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - DEPTH x WW storage, one write port and one registered read port
module data_mem_array #(
  parameter int WW    = 8,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [WW-1:0] wr_word,
  input  logic          rd_en,
  input  logic          rd_zero,
  input  logic [AW-1:0] rd_addr,
  output logic [WW-1:0] rd_word
);

  // Storage carries no reset; the controller's clear sequencer zeroes it
  logic [WW-1:0] mem [DEPTH];

  // Single write port; the controller guarantees wr_addr < DEPTH whenever wr_en is set
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_word;
    end
  end

  // Registered read; holds its value between reads, and rd_zero substitutes 0 for out-of-range reads
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_word <= '0;
    end else if (rd_en) begin
      rd_word <= rd_zero ? '0 : mem[rd_addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - handshaked data memory with clear sequencer; optional parity under DATA_MEM_PARITY_EN
import data_mem_pkg::*;

module data_mem_ctrl #(
  parameter int DW             = DEF_DW,
  parameter int AW             = DEF_AW,
  parameter int DEPTH          = DEF_DEPTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          ClearStart,
  input  logic          ReqValid,
  output logic          ReqReady,
  input  logic          ReqWrite,
  input  logic [AW-1:0] ReqAddr,
  input  logic [DW-1:0] ReqWData,
  output logic          RspValid,
  output logic [DW-1:0] RspData,
`ifdef DATA_MEM_PARITY_EN
  input  logic          ParFlip,
  output logic          RspErr,
`endif
  output logic          Busy
);

`ifdef DATA_MEM_PARITY_EN
  localparam int WW = DW + 1;
`else
  localparam int WW = DW;
`endif

  logic [0:0]    state;
  logic [AW-1:0] ptr;
  logic          accept;
  logic          in_range;
  logic          ptr_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_word;
  logic          rd_en;
  logic [WW-1:0] rd_word;

  assign Busy     = (state == S_CLEAR);
  assign ReqReady = (state == S_IDLE) && !ClearStart;
  assign accept   = ReqValid && ReqReady;
  assign in_range = (32'(ReqAddr) < 32'(DEPTH));
  assign ptr_last = (32'(ptr) == 32'(DEPTH - 1));
  assign rd_en    = accept && !ReqWrite;

  // Write port mux: the clear sequencer owns the port in CLEAR, accepted in-range writes otherwise
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ReqAddr;
    wr_word = '0;
    if (state == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = ptr;
    end else if (accept && ReqWrite && in_range) begin
      wr_en = 1'b1;
`ifdef DATA_MEM_PARITY_EN
      wr_word = {even_parity(64'(ReqWData)) ^ ParFlip, ReqWData};
`else
      wr_word = ReqWData;
`endif
    end
  end

  // FSM and clear pointer; ClearStart only matters in IDLE and always restarts from word 0
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      ptr   <= '0;
    end else if (state == S_CLEAR) begin
      if (ptr_last) begin
        state <= S_IDLE;
        ptr   <= '0;
      end else begin
        ptr <= ptr + AW'(1);
      end
    end else if (ClearStart) begin
      state <= S_CLEAR;
      ptr   <= '0;
    end
  end

  // Response strobe: one-cycle pulse following each accepted read
  always_ff @(posedge Clk) begin
    if (Reset) begin
      RspValid <= 1'b0;
    end else begin
      RspValid <= rd_en;
    end
  end

  data_mem_array #(
    .WW    (WW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_array (
    .Clk     (Clk),
    .Reset   (Reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_word (wr_word),
    .rd_en   (rd_en),
    .rd_zero (!in_range),
    .rd_addr (ReqAddr),
    .rd_word (rd_word)
  );

  assign RspData = rd_word[DW-1:0];

`ifdef DATA_MEM_PARITY_EN
  // Stored parity checked against parity recomputed from the stored data
  assign RspErr = rd_word[DW] ^ even_parity(64'(rd_word[DW-1:0]));
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl (DEPTH 256 and DEPTH 200 instances)
module tb_data_mem_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ClearStart = 1'b0;
  logic       ReqValid = 1'b0;
  logic       ReqWrite = 1'b0;
  logic [7:0] ReqAddr = 8'h00;
  logic [7:0] ReqWData = 8'h00;

  logic       ReqReady_a, RspValid_a, Busy_a;
  logic [7:0] RspData_a;
  logic       ReqReady_b, RspValid_b, Busy_b;
  logic [7:0] RspData_b;
`ifdef DATA_MEM_PARITY_EN
  logic       ParFlip = 1'b0;
  logic       RspErr_a, RspErr_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[11];

  always #5 Clk = ~Clk;

  data_mem_ctrl #(.DW(8), .AW(8), .DEPTH(256), .CLEAR_ON_RESET(1'b1)) dut_a (
    .Clk(Clk), .Reset(Reset), .ClearStart(ClearStart),
    .ReqValid(ReqValid), .ReqReady(ReqReady_a), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RspValid(RspValid_a), .RspData(RspData_a),
`ifdef DATA_MEM_PARITY_EN
    .ParFlip(ParFlip), .RspErr(RspErr_a),
`endif
    .Busy(Busy_a)
  );

  data_mem_ctrl #(.DW(8), .AW(8), .DEPTH(200), .CLEAR_ON_RESET(1'b1)) dut_b (
    .Clk(Clk), .Reset(Reset), .ClearStart(ClearStart),
    .ReqValid(ReqValid), .ReqReady(ReqReady_b), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RspValid(RspValid_b), .RspData(RspData_b),
`ifdef DATA_MEM_PARITY_EN
    .ParFlip(ParFlip), .RspErr(RspErr_b),
`endif
    .Busy(Busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Samples Busy once per cycle starting at the current negedge; bounded at 400 cycles
  task automatic count_clear(input int exp_a, input int exp_b);
    int cnt_a = 0;
    int cnt_b = 0;
    int ready_hi = 0;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (Busy_a) cnt_a++;
      if (Busy_b) cnt_b++;
      if (Busy_a && ReqReady_a) ready_hi++;
      if (!Busy_a && !Busy_b) break;
      @(negedge Clk);
    end
    check("busy_cycles_a", cnt_a, exp_a);
    check("busy_cycles_b", cnt_b, exp_b);
    check("ready_during_clear", ready_hi, 0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    check("reset_rspvalid", RspValid_a, 0);
    check("reset_rspdata", RspData_a, 0);
    check("reset_busy", Busy_a, 1);
    @(negedge Clk);
    Reset = 1'b0;
    count_clear(256, 200);
  endtask

  task automatic req(input logic wr, input logic [7:0] addr, input logic [7:0] data);
    @(negedge Clk);
    ReqValid = 1'b1;
    ReqWrite = wr;
    ReqAddr  = addr;
    ReqWData = data;
    #1;
    check("req_ready", ReqReady_a, 1);
    @(posedge Clk);
    #1;
  endtask

  task automatic go_idle();
    @(negedge Clk);
    ReqValid   = 1'b0;
    ClearStart = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] last_rd;

    vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 8'h7F, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 8'hFF, 8'h00, 8'h00};
    vecs[3]  = '{1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[4]  = '{1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[5]  = '{1'b1, 8'hFF, 8'h3C, 8'h00};
    vecs[6]  = '{1'b0, 8'hFF, 8'h00, 8'h3C};
    vecs[7]  = '{1'b1, 8'h00, 8'h11, 8'h00};
    vecs[8]  = '{1'b1, 8'h01, 8'h22, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 8'h00, 8'h11};
    vecs[10] = '{1'b0, 8'h01, 8'h00, 8'h22};

    // Reset, then full clear of both instances
    do_reset();

    // Table: back-to-back requests against the DEPTH=256 instance
    last_rd = 8'h00;
    for (int i = 0; i < 11; i++) begin
      req(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d_wr_rspvalid", i), RspValid_a, 0);
        check($sformatf("vec%0d_wr_hold", i), RspData_a, last_rd);
      end else begin
        check($sformatf("vec%0d_rspvalid", i), RspValid_a, 1);
        check($sformatf("vec%0d_rspdata", i), RspData_a, vecs[i].exp);
        last_rd = vecs[i].exp;
      end
    end

    // Out-of-range on the DEPTH=200 instance; in-range word 199 behaves normally
    req(1'b1, 8'd210, 8'h77);
    check("oor_wr_rspvalid_b", RspValid_b, 0);
    req(1'b0, 8'd210, 8'h00);
    check("oor_rd_rspvalid_b", RspValid_b, 1);
    check("oor_rd_rspdata_b", RspData_b, 8'h00);
    check("inrange_210_rspdata_a", RspData_a, 8'h77);
    req(1'b1, 8'd199, 8'h99);
    req(1'b0, 8'd199, 8'h00);
    check("edge199_rspvalid_b", RspValid_b, 1);
    check("edge199_rspdata_b", RspData_b, 8'h99);
    check("edge199_rspdata_a", RspData_a, 8'h99);
    go_idle();
    @(posedge Clk);
    #1;
    check("pulse_rspvalid_a", RspValid_a, 0);
    check("hold_rspdata_a", RspData_a, 8'h99);

    // ClearStart collides with a write: write dropped, clear starts next cycle
    @(negedge Clk);
    ClearStart = 1'b1;
    ReqValid   = 1'b1;
    ReqWrite   = 1'b1;
    ReqAddr    = 8'h20;
    ReqWData   = 8'h55;
    #1;
    check("collide_ready_a", ReqReady_a, 0);
    check("collide_busy_before", Busy_a, 0);
    @(posedge Clk);
    #1;
    check("collide_busy_after", Busy_a, 1);
    @(negedge Clk);
    ClearStart = 1'b0;
    ReqValid   = 1'b0;
    count_clear(256, 200);
    req(1'b0, 8'h20, 8'h00);
    check("after_clear_20", RspData_a, 8'h00);
    req(1'b0, 8'hFF, 8'h00);
    check("after_clear_ff", RspData_a, 8'h00);
    req(1'b0, 8'h10, 8'h00);
    check("after_clear_10", RspData_a, 8'h00);
    check("after_clear_10_valid", RspValid_a, 1);
    go_idle();

    // Reset during a clear restarts the full sequence
    @(negedge Clk);
    ClearStart = 1'b1;
    @(negedge Clk);
    ClearStart = 1'b0;
    repeat (99) @(negedge Clk);
    #1;
    check("midclear_busy", Busy_a, 1);
    do_reset();

`ifdef DATA_MEM_PARITY_EN
    ParFlip = 1'b1;
    req(1'b1, 8'h05, 8'h0F);
    ParFlip = 1'b0;
    req(1'b0, 8'h05, 8'h00);
    check("par_flip_err", RspErr_a, 1);
    check("par_flip_data", RspData_a, 8'h0F);
    req(1'b1, 8'h05, 8'h0F);
    req(1'b0, 8'h05, 8'h00);
    check("par_clean_err", RspErr_a, 0);
    check("par_clean_data", RspData_a, 8'h0F);
    go_idle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised single-port data memory for the processor datapath, the next generation of the 8x256 combinational data store.
- Adds a valid/ready request handshake and a registered (1-cycle) read.
- Replaces the single-cycle reset clear with a hardware clear sequencer that zeroes one word per cycle, after reset or on request.
- Sits between the load/store unit and the storage array.

Parameters:
DW, 8, data word width in bits
AW, 8, address width in bits
DEPTH, 256, number of implemented words; must satisfy DEPTH <= 2**AW
CLEAR_ON_RESET, 1, when 1 reset enters CLEAR; when 0 reset enters IDLE and memory contents are undefined

Ports:
Clk  input  1  clock; all state updates on posedge
Reset  input  1  synchronous, active-high reset
ClearStart  input  1  pulse in IDLE starts a full clear
ReqValid  input  1  request present
ReqReady  output  1  request can be accepted this cycle
ReqWrite  input  1  1 = write, 0 = read
ReqAddr  input  AW  word address
ReqWData  input  DW  write data
RspValid  output  1  read data valid, single-cycle pulse
RspData  output  DW  read data
Busy  output  1  clear sequence in progress

Behaviour:
- Reset is synchronous, active-high, on Clk.
- Reset values: RspValid=0, RspData=0, clear pointer=0. State goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
- States:
  - CLEAR: each cycle write 0 to word[ptr], then ptr++. On ptr==DEPTH-1, write that word and go to IDLE next cycle.
  - IDLE: serve requests.
  - A full clear therefore takes exactly DEPTH cycles.
- Busy = (state==CLEAR), combinational from state.
- ReqReady = (state==IDLE) && !ClearStart, combinational.
- ClearStart priority:
  - ClearStart and ReqValid in the same IDLE cycle: the request is not accepted; CLEAR starts next cycle with ptr=0.
  - ClearStart is ignored in CLEAR.
- Accept = ReqValid && ReqReady.
- Write accept: word[ReqAddr] <= ReqWData at that edge. No response is generated.
- Read accept: RspData <= word[ReqAddr] and RspValid <= 1 at that edge. Read latency is 1 cycle. RspValid is 0 on any cycle without a read accept. RspData holds its last value when RspValid=0.
- Back-to-back ordering: a write at cycle N followed by a read of the same address at N+1 returns the new data.
- Out-of-range address (ReqAddr >= DEPTH, only possible when DEPTH < 2**AW):
  - Writes are dropped.
  - Reads return 0 with RspValid=1.
- Reset mid-clear restarts the clear from ptr=0 (CLEAR_ON_RESET=1).
- Reset on the cycle after a read accept forces RspValid=0; that response is lost.
- No backpressure on responses; the consumer must always sink RspValid.

Optional Feature:
Macro DATA_MEM_PARITY_EN.
- Defined:
  - Each word stores DW data bits plus an even-parity bit, computed on write.
  - CLEAR writes parity 0.
  - Output port RspErr (1 bit) is valid with RspValid. It is 1 when the stored parity mismatches recomputed parity of the stored data. Reset value 0.
  - Input port ParFlip (1 bit) inverts the stored parity bit on any write accepted in the same cycle; used for error injection.
- Undefined: no parity storage and no RspErr/ParFlip ports; behaviour is otherwise identical.

Decomposition:
- Package data_mem_pkg:
  - state enum {S_IDLE, S_CLEAR}.
  - Default DW/AW/DEPTH localparams.
  - Parity function.
- Sub-module data_mem_array:
  - DEPTH x (DW[+1]) storage, one write port, one registered read port.
  - No reset on its storage.
  - The controller owns the FSM, handshake and clear pointer.

Test Plan:
- Clear after reset: Reset 1 cycle, DEPTH=256 -> Busy=1 for exactly 256 cycles, ReqReady=0 throughout; then read addr 0x00, 0x7F, 0xFF -> RspData=0x00 each, RspValid one cycle after accept.
- Write then read: write 0xA5 to addr 0x10 at cycle N, read addr 0x10 at N+1 -> RspValid at N+2, RspData=0xA5. Write 0x3C to 0xFF then read -> 0x3C.
- ClearStart collision: ClearStart=1 with ReqValid=1 (write 0x55 to 0x20) in IDLE -> ReqReady=0, write dropped, Busy rises next cycle; after clear, read 0x20 -> 0x00.
- Reset mid-clear: assert Reset at clear cycle 100 -> ptr restarts; Busy stays high for a further 256 cycles counted from Reset deassertion.
- Out of range: DEPTH=200, AW=8; write 0x77 to addr 210, then read 210 -> RspData=0x00, RspValid=1; addr 199 read/write works normally.
- Parity (DATA_MEM_PARITY_EN): write 0x0F with ParFlip=1 to addr 5, read -> RspErr=1. Rewrite 0x0F with ParFlip=0, read -> RspErr=0.
